// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues word-aligned fetches and buffers the
// returned words in order. A redirect flushes younger entries and drops in-flight data.
module instr_fetch #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] BranchTarget
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_W = DEPTH[PW:0];

  logic [WIDTH-1:0] pc_mem   [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  // Pointers carry one wrap bit so full and empty are distinguishable.
  // Entries in [head, fill) are filled; [fill, alloc) are awaiting data.
  logic [PW-1:0]    alloc_ptr_reg;
  logic [PW-1:0]    fill_ptr_reg;
  logic [PW-1:0]    head_ptr_reg;
  logic [PW-1:0]    discard_reg;
  logic [WIDTH-1:0] fetch_pc_reg;

  logic [PW-1:0]    occupancy;
  logic [PW-1:0]    unfilled;
  logic             credit_ok;
  logic             req_fire;
  logic             pop;
  logic             fill_we;
  logic [AW-1:0]    alloc_idx;
  logic [AW-1:0]    fill_idx;
  logic [AW-1:0]    head_idx;

  assign alloc_idx = alloc_ptr_reg[AW-1:0];
  assign fill_idx  = fill_ptr_reg[AW-1:0];
  assign head_idx  = head_ptr_reg[AW-1:0];

  assign occupancy = alloc_ptr_reg - head_ptr_reg;
  assign unfilled  = alloc_ptr_reg - fill_ptr_reg;
  // Credit counts words still owed by memory for flushed fetches, so their
  // responses can never overrun the buffer.
  assign credit_ok = ({1'b0, occupancy} + {1'b0, discard_reg}) < DEPTH_W;

  assign imem_req_valid = !rst && !PCsrc && credit_ok;
  assign imem_addr      = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = !rst && (fill_ptr_reg != head_ptr_reg);
  assign instr       = data_mem[head_idx];
  assign instr_pc    = pc_mem[head_idx];
  assign pop         = instr_valid && instr_ready;

  assign fill_we = imem_rsp_valid && !PCsrc && (discard_reg == '0);

  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_mem[alloc_idx] <= fetch_pc_reg;
    end
    if (fill_we) begin
      data_mem[fill_idx] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      discard_reg   <= '0;
      fetch_pc_reg  <= RESET_PC;
    end else if (PCsrc) begin
      // Any response this cycle belongs to the oldest outstanding fetch, which
      // is either already owed to discard or one of the unfilled entries.
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      discard_reg   <= discard_reg + unfilled - {{AW{1'b0}}, imem_rsp_valid};
      fetch_pc_reg  <= {BranchTarget[WIDTH-1:2], 2'b00};
    end else begin
      if (req_fire) begin
        alloc_ptr_reg <= alloc_ptr_reg + PW'(1);
        fetch_pc_reg  <= fetch_pc_reg + WIDTH'(4);
      end
      if (imem_rsp_valid) begin
        if (discard_reg != '0) begin
          discard_reg <= discard_reg - PW'(1);
        end else begin
          fill_ptr_reg <= fill_ptr_reg + PW'(1);
        end
      end
      if (pop) begin
        head_ptr_reg <= head_ptr_reg + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model of the fetch buffer plus an
// in-order memory with random latency; directed phases followed by random traffic.
module tb_instr_fetch;
  localparam int          WIDTH    = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        PCsrc = 1'b0;
  logic [31:0] BranchTarget = '0;

  always #5 clk = ~clk;

  instr_fetch #(.WIDTH(WIDTH), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .PCsrc(PCsrc), .BranchTarget(BranchTarget)
  );

  typedef struct {logic [31:0] pc; logic [31:0] data; bit filled;} ent_t;
  typedef struct {logic [31:0] addr; int due;} mreq_t;

  ent_t        mbuf[$];
  mreq_t       memq[$];
  int          mdiscard = 0;
  logic [31:0] mpc = RESET_PC;
  bit          exp_req_valid, exp_instr_valid;
  int          cyc = 0, last_due = 0;
  int          lat_min = 1, lat_max = 1;
  bit          hold = 1'b0;
  int          fire_count = 0;
  int          n_checks = 0, n_pass = 0;
  bit          seen;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive the memory response for this cycle, then compare DUT against the model.
  task automatic prep();
    if (!rst && !hold && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    exp_req_valid   = !rst && !PCsrc && (mbuf.size() + mdiscard < DEPTH);
    exp_instr_valid = !rst && mbuf.size() > 0 && mbuf[0].filled;
    chk("req_valid", imem_req_valid, exp_req_valid);
    if (exp_req_valid) chk("imem_addr", imem_addr, mpc);
    chk("instr_valid", instr_valid, exp_instr_valid);
    if (exp_instr_valid) begin
      chk("instr", instr, mbuf[0].data);
      chk("instr_pc", instr_pc, mbuf[0].pc);
    end
  endtask

  // Clock edge: advance model and memory with the inputs held through the edge.
  task automatic adv();
    bit fire, popv;
    int d, idx;
    @(posedge clk);
    fire = exp_req_valid && imem_req_ready;
    popv = exp_instr_valid && instr_ready;
    if (rst) begin
      mbuf.delete();
      memq.delete();
      mdiscard = 0;
      mpc = RESET_PC;
      last_due = cyc;
    end else begin
      if (imem_rsp_valid) void'(memq.pop_front());
      if (fire) begin
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d <= last_due) d = last_due + 1;
        memq.push_back('{addr: mpc, due: d});
        last_due = d;
        fire_count++;
      end
      if (PCsrc) begin
        idx = 0;
        foreach (mbuf[i]) if (!mbuf[i].filled) idx++;
        mdiscard = mdiscard + idx - (imem_rsp_valid ? 1 : 0);
        mbuf.delete();
        mpc = {BranchTarget[31:2], 2'b00};
      end else begin
        if (imem_rsp_valid) begin
          if (mdiscard > 0) mdiscard--;
          else begin
            idx = -1;
            foreach (mbuf[i]) if (idx < 0 && !mbuf[i].filled) idx = i;
            if (idx >= 0) begin
              mbuf[idx].data   = imem_rsp_data;
              mbuf[idx].filled = 1'b1;
            end
          end
        end
        if (popv) void'(mbuf.pop_front());
        if (fire) begin
          mbuf.push_back('{pc: mpc, data: 32'h0, filled: 1'b0});
          mpc = mpc + 32'd4;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    PCsrc = 1'b0;
    for (int i = 0; i < n; i++) begin
      prep();
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_instr_valid", instr_valid, 1'b0);
      adv();
    end
    rst = 1'b0;
  endtask

  // Step until the selected output is high (0: req_valid, 1: instr_valid); leaves
  // the cycle prepped so literal checks can follow.
  task automatic wait_for(int sel, string name);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prep();
      if ((sel == 0) ? imem_req_valid : instr_valid) begin
        seen = 1'b1;
        break;
      end
      adv();
    end
    if (!seen) begin
      chk(name, {31'b0, seen}, 32'd1);
      prep();
    end
  endtask

  initial begin
    logic [31:0] r;
    @(posedge clk);
    #1;

    // Reset release with 1-cycle memory and a decoder always ready.
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    do_reset(2);
    prep(); chk("A_first_req_valid", imem_req_valid, 1'b1); chk("A_first_addr", imem_addr, 32'h0); adv();
    prep(); chk("A_second_addr", imem_addr, 32'h4); adv();
    prep(); chk("A_head0_valid", instr_valid, 1'b1); chk("A_head0_pc", instr_pc, 32'h0); adv();
    prep(); chk("A_head1_pc", instr_pc, 32'h4); chk("A_head1_data", instr, mem_word(32'h4)); adv();

    // Decoder stalled: buffer fills after DEPTH requests.
    do_reset(1);
    instr_ready = 1'b0;
    fire_count = 0;
    for (int i = 0; i < 6; i++) begin prep(); adv(); end
    chk("B_req_count", fire_count, 32'd2);
    prep(); chk("B_stalled", imem_req_valid, 1'b0); chk("B_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    adv();
    prep(); chk("B_resume_valid", imem_req_valid, 1'b1); chk("B_resume_addr", imem_addr, 32'h8);
    chk("B_next_head", instr_pc, 32'h4); adv();

    // Redirect with two fetches in flight: both responses must be dropped.
    do_reset(1);
    hold = 1'b1;
    prep(); adv(); prep(); adv();
    prep(); chk("C_full", imem_req_valid, 1'b0); adv();
    PCsrc = 1'b1; BranchTarget = 32'h103;
    prep(); chk("C_no_req_redirect", imem_req_valid, 1'b0); adv();
    PCsrc = 1'b0; hold = 1'b0;
    prep(); chk("C_owed_credit", imem_req_valid, 1'b0); adv();
    wait_for(0, "C_req_timeout"); chk("C_target_addr", imem_addr, 32'h100); adv();
    wait_for(1, "C_instr_timeout"); chk("C_first_pc", instr_pc, 32'h100); adv();

    // Redirect in the same cycle as a response and a head pop.
    do_reset(1);
    prep(); adv(); prep(); adv();
    PCsrc = 1'b1; BranchTarget = 32'h200;
    prep(); chk("D_pop_pc", instr_pc, 32'h0); chk("D_pop_valid", instr_valid, 1'b1); adv();
    PCsrc = 1'b0;
    wait_for(1, "D_instr_timeout"); chk("D_first_after", instr_pc, 32'h200); adv();

    // Address wrap at the top of the address space.
    PCsrc = 1'b1; BranchTarget = 32'hFFFF_FFFE;
    prep(); adv();
    PCsrc = 1'b0;
    wait_for(0, "E_req_timeout"); chk("E_top_addr", imem_addr, 32'hFFFF_FFFC); adv();
    wait_for(0, "E_wrap_timeout"); chk("E_wrap_addr", imem_addr, 32'h0); adv();

    // Reset with filled entries and outstanding requests.
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin prep(); adv(); end
    hold = 1'b1;
    prep(); adv();
    rst = 1'b1;
    prep(); chk("F_rst_instr_valid", instr_valid, 1'b0); adv();
    rst = 1'b0; hold = 1'b0;
    prep(); chk("F_restart_valid", imem_req_valid, 1'b1); chk("F_restart_addr", imem_addr, RESET_PC);
    chk("F_empty", instr_valid, 1'b0); adv();

    // Randomized traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(99, 0) < 75);
      instr_ready    = ($urandom_range(99, 0) < 70);
      PCsrc          = ($urandom_range(99, 0) < 6);
      rst            = ($urandom_range(999, 0) < 5);
      r = $urandom;
      BranchTarget   = (r[1:0] == 2'b00) ? {28'hFFFF_FFF, r[7:4]} : $urandom;
      prep();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
